// File: rtl/clkdiv_prog_pkg.sv
// Shared types and helpers for the programmable clock-enable generator.
// Holds the load-mode encoding, the channel phase set and the select-width helper.
package clkdiv_prog_pkg;

   localparam int unsigned DEF_DIV_RESET = 4;

   typedef enum logic {
      LD_DEFER = 1'b0,
      LD_NOW   = 1'b1
   } ld_mode_e;

   typedef enum logic [1:0] {
      CH_PARKED = 2'd0,
      CH_HOLD   = 2'd1,
      CH_RUN    = 2'd2,
      CH_TERM   = 2'd3
   } ch_phase_e;

   // Width of a channel index; never less than one bit so a single channel still has a port.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clkdiv_prog_chan.sv
// One divider channel: programmable divisor, deferred or immediate reload, tick strobe and square wave.
//
// phase     | meaning
// CH_PARKED | div_act == 0, counter and square wave held at zero
// CH_HOLD   | en low, count and square wave frozen
// CH_RUN    | counting towards the terminal count
// CH_TERM   | terminal edge: tick, toggle sq, pick up any pending divisor
module clkdiv_prog_chan
   import clkdiv_prog_pkg::*;
#(
   parameter int unsigned DW      = 16,
   parameter int unsigned DEF_DIV = DEF_DIV_RESET
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          ld,
   input  logic          ld_now,
   input  logic [DW-1:0] ld_div,
   output logic          tick,
   output logic          sq
);

   logic [DW-1:0] div_act_q, div_act_d;
   logic [DW-1:0] div_pend_q, div_pend_d;
   logic          pend_vld_q, pend_vld_d;
   logic [DW-1:0] ch_cnt_q, ch_cnt_d;
   logic          tick_q, tick_d;
   logic          sq_q, sq_d;
   ch_phase_e     phase;

   always_comb begin
      if (div_act_q == '0) begin
         phase = CH_PARKED;
      end else if (!en) begin
         phase = CH_HOLD;
      end else if (ch_cnt_q == div_act_q - DW'(1)) begin
         phase = CH_TERM;
      end else begin
         phase = CH_RUN;
      end
   end

   always_comb begin
      div_act_d  = div_act_q;
      div_pend_d = div_pend_q;
      pend_vld_d = pend_vld_q;
      ch_cnt_d   = ch_cnt_q;
      tick_d     = 1'b0;
      sq_d       = sq_q;

      unique case (phase)
         CH_PARKED: begin
            ch_cnt_d = '0;
            sq_d     = 1'b0;
            if (en && pend_vld_q) begin
               div_act_d  = div_pend_q;
               pend_vld_d = 1'b0;
            end
         end
         CH_HOLD: begin
            ch_cnt_d = ch_cnt_q;
         end
         CH_RUN: begin
            ch_cnt_d = ch_cnt_q + DW'(1);
         end
         CH_TERM: begin
            ch_cnt_d = '0;
            tick_d   = 1'b1;
            sq_d     = ~sq_q;
            if (pend_vld_q) begin
               div_act_d  = div_pend_q;
               pend_vld_d = 1'b0;
            end
         end
         default: begin
            ch_cnt_d = ch_cnt_q;
         end
      endcase

      // A load overrides the free-running update; a deferred load landing on a
      // terminal edge takes effect at once so the new period starts right away.
      if (ld) begin
         if (ld_mode_e'(ld_now) == LD_NOW) begin
            div_act_d  = ld_div;
            ch_cnt_d   = '0;
            tick_d     = 1'b0;
            sq_d       = sq_q;
            pend_vld_d = 1'b0;
         end else if (phase == CH_TERM) begin
            div_act_d  = ld_div;
            pend_vld_d = 1'b0;
         end else begin
            div_pend_d = ld_div;
            pend_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_act_q  <= DW'(DEF_DIV);
         div_pend_q <= DW'(DEF_DIV);
         pend_vld_q <= 1'b0;
         ch_cnt_q   <= '0;
         tick_q     <= 1'b0;
         sq_q       <= 1'b0;
      end else begin
         div_act_q  <= div_act_d;
         div_pend_q <= div_pend_d;
         pend_vld_q <= pend_vld_d;
         ch_cnt_q   <= ch_cnt_d;
         tick_q     <= tick_d;
         sq_q       <= sq_d;
      end
   end

   assign tick = tick_q;
   assign sq   = sq_q;

endmodule

// File: rtl/clkdiv_prog.sv
// Free-running counter plus NCH programmable clock-enable channels.
// Load requests are decoded by channel index; out-of-range indices are dropped.
module clkdiv_prog
   import clkdiv_prog_pkg::*;
#(
   parameter  int unsigned WIDTH   = 32,
   parameter  int unsigned NCH     = 4,
   parameter  int unsigned DW      = 16,
   parameter  int unsigned DEF_DIV = DEF_DIV_RESET,
   localparam int unsigned CHW     = sel_width(NCH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             ld_en,
   input  logic [CHW-1:0]   ld_ch,
   input  logic [DW-1:0]    ld_div,
   input  logic             ld_now,
   output logic [WIDTH-1:0] cnt,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   sq
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [NCH-1:0]   ld_vec;

   assign cnt_d = cnt_q + WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

   always_comb begin
      ld_vec = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         ld_vec[i] = ld_en && (ld_ch == CHW'(i));
      end
   end

   for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
      clkdiv_prog_chan #(
         .DW      (DW),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (en),
         .ld     (ld_vec[g]),
         .ld_now (ld_now),
         .ld_div (ld_div),
         .tick   (tick[g]),
         .sq     (sq[g])
      );
   end

endmodule
